button_reader: RTL and testbench
================================

BUTTON_READER -- requirements
Module: button_reader

Interface
REQ-001 Parameter NUM_BTN, default 4: number of push-button channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 250000: cycles an input must hold stable before a level change is accepted, legal range 2..2^24-1.
REQ-003 Parameter LONG_CYCLES, default 10000000: cycles of accepted press before the long-press event fires, must be greater than DEBOUNCE_CYCLES, max 2^24-1.
REQ-004 Parameter ACTIVE_LOW, default 1: 1 means raw pin low = pressed; 0 means raw pin high = pressed.
REQ-005 clk_in, input, 1 bit: the only clock; all state is on its rising edge.
REQ-006 rst_in, input, 1 bit: reset, asynchronous, active-high.
REQ-007 btn_raw, input, NUM_BTN bits: asynchronous, bouncing button pins.
REQ-008 btn_level, output, NUM_BTN bits: debounced pressed state, 1 = pressed.
REQ-009 btn_press, output, NUM_BTN bits: one-cycle pulse when a press is accepted.
REQ-010 btn_release, output, NUM_BTN bits: one-cycle pulse when a release is accepted.
REQ-011 btn_long, output, NUM_BTN bits: one-cycle pulse, at most once per accepted press.
REQ-012 any_press, output, 1 bit: registered OR of btn_press, delayed by 1 cycle.

Function
REQ-013 Each channel normalises polarity (pressed = 1), then passes the signal through a 2-flop synchroniser; s denotes the second flop's output.
REQ-014 Each channel is independent and runs a 4-state FSM: IDLE, PRESS_WAIT, HELD, RELEASE_WAIT.
REQ-015 IDLE: if s=1, go to PRESS_WAIT and clear the debounce counter; otherwise stay.
REQ-016 PRESS_WAIT: if s=0, return to IDLE with no pulse (bounce rejected); otherwise increment the counter; on the cycle the counter equals DEBOUNCE_CYCLES-1 with s=1, go to HELD, pulse btn_press, set btn_level=1, and clear the hold counter.
REQ-017 HELD: the hold counter increments and saturates at LONG_CYCLES-1; on the cycle it reaches LONG_CYCLES-1, pulse btn_long exactly once; if s=0, go to RELEASE_WAIT and clear the debounce counter.
REQ-018 RELEASE_WAIT: if s=1, return to HELD with no pulse, keeping hold counter and long-fired status; otherwise increment; at DEBOUNCE_CYCLES-1, go to IDLE, pulse btn_release, set btn_level=0.
REQ-019 Latency: a clean raw press edge produces btn_press exactly DEBOUNCE_CYCLES+2 cycles later; release is symmetric.
REQ-020 All outputs are registered; no combinational path exists from btn_raw to any output.
REQ-021 Counter widths are $clog2(LONG_CYCLES) bits for the hold counter and $clog2(DEBOUNCE_CYCLES) bits for the debounce counter; no counter wraps.
REQ-022 btn_press and btn_release never assert in the same cycle on the same channel; simultaneous events on different channels all pulse in the same cycle.
REQ-023 A press shorter than DEBOUNCE_CYCLES produces no pulses and leaves btn_level unchanged.

Reset
REQ-024 While rst_in=1: all FSMs are in IDLE, counters and synchroniser flops are 0 (released), and btn_level, btn_press, btn_release, btn_long and any_press are 0.
REQ-025 Reset asserted mid-press drops btn_level to 0 immediately, with no btn_release pulse.
REQ-026 A button held through reset deassertion is treated as a new press: btn_press fires DEBOUNCE_CYCLES+2 cycles after release of reset.

Structure
REQ-027 A shared package holds the FSM state enum btn_state_t (2-bit encoding) and the default timing constants.
REQ-028 One sub-module, button_channel (synchroniser, counters, FSM), is instantiated NUM_BTN times by a generate loop.

Verification (NUM_BTN=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=10, ACTIVE_LOW=1)
REQ-029 Clean press: btn_raw[0] driven 1->0 and held -> btn_press[0] pulses at cycle 6, btn_level[0]=1 from cycle 6, any_press=1 at cycle 7.
REQ-030 Bounce: btn_raw[1] toggled with high/low widths of 3 cycles for 30 cycles, then released -> no btn_press[1], btn_release[1] or btn_long[1] pulse; btn_level[1] stays 0.
REQ-031 Long press: btn_raw[2] held low for 20 cycles -> btn_press[2] at cycle 6, btn_long[2] exactly once at cycle 15, btn_release[2] 6 cycles after the raw release.
REQ-032 Release glitch: a 2-cycle high glitch while HELD -> no release pulse, btn_level stays 1, btn_long does not repeat.
REQ-033 Reset mid-press: rst_in pulsed at cycle 8 of a held press -> all outputs 0 within the same cycle; a press still held after reset deasserts produces btn_press 6 cycles later.
REQ-034 Simultaneous press: all 4 buttons pressed in the same cycle -> all 4 btn_press bits pulse together at cycle 6, and any_press pulses once.

Source files
------------

// File: rtl/button_reader_pkg.sv
// Shared types and default timing for the debounced push-button reader.
package button_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_PRESS_WAIT   = 2'd1,
      ST_HELD         = 2'd2,
      ST_RELEASE_WAIT = 2'd3
   } btn_state_t;

   localparam int DEFAULT_NUM_BTN         = 4;
   localparam int DEFAULT_DEBOUNCE_CYCLES = 250000;
   localparam int DEFAULT_LONG_CYCLES     = 10000000;
   localparam int DEFAULT_ACTIVE_LOW      = 1;

endpackage

// File: rtl/button_channel.sv
// One button: polarity normalisation, 2-flop synchroniser, debounce and
// long-press FSM with registered level and event pulses.
module button_channel
   import button_reader_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
   parameter int ACTIVE_LOW      = DEFAULT_ACTIVE_LOW
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic rel_o,
   output logic long_o
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int HW = $clog2(LONG_CYCLES);
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_CYCLES - 2);

   logic          pressed_d;
   logic          sync1_q;
   logic          sync2_q;
   btn_state_t    state_q;
   logic [DW-1:0] deb_q;
   logic [HW-1:0] hold_q;
   logic          level_q;
   logic          press_q;
   logic          rel_q;
   logic          long_q;

   assign pressed_d = (ACTIVE_LOW != 0) ? ~raw_i : raw_i;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= pressed_d;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         deb_q   <= '0;
         hold_q  <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         long_q  <= 1'b0;
      end else begin
         press_q <= 1'b0;
         rel_q   <= 1'b0;
         long_q  <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (sync2_q) begin
                  state_q <= ST_PRESS_WAIT;
                  deb_q   <= '0;
               end
            end
            ST_PRESS_WAIT: begin
               if (!sync2_q) begin
                  state_q <= ST_IDLE;
               end else if (deb_q == DEB_LAST) begin
                  state_q <= ST_HELD;
                  press_q <= 1'b1;
                  level_q <= 1'b1;
                  hold_q  <= '0;
               end else begin
                  deb_q <= deb_q + 1'b1;
               end
            end
            ST_HELD: begin
               // Saturating hold count makes the long pulse fire once per press,
               // even across rejected release glitches.
               if (hold_q != HOLD_LAST) begin
                  hold_q <= hold_q + 1'b1;
                  long_q <= (hold_q == HOLD_PRE);
               end
               if (!sync2_q) begin
                  state_q <= ST_RELEASE_WAIT;
                  deb_q   <= '0;
               end
            end
            ST_RELEASE_WAIT: begin
               if (sync2_q) begin
                  state_q <= ST_HELD;
               end else if (deb_q == DEB_LAST) begin
                  state_q <= ST_IDLE;
                  rel_q   <= 1'b1;
                  level_q <= 1'b0;
               end else begin
                  deb_q <= deb_q + 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;
   assign rel_o   = rel_q;
   assign long_o  = long_q;

endmodule

// File: rtl/button_reader.sv
// Multi-channel debounced button reader with press/release/long events.
module button_reader
   import button_reader_pkg::*;
#(
   parameter int NUM_BTN         = DEFAULT_NUM_BTN,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
   parameter int ACTIVE_LOW      = DEFAULT_ACTIVE_LOW
) (
   input  logic               clk_in,
   input  logic               rst_in,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic [NUM_BTN-1:0] btn_long,
   output logic               any_press
);

   logic any_q;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_ch
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES),
         .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_ch (
         .clk_i   (clk_in),
         .rst_i   (rst_in),
         .raw_i   (btn_raw[gi]),
         .level_o (btn_level[gi]),
         .press_o (btn_press[gi]),
         .rel_o   (btn_release[gi]),
         .long_o  (btn_long[gi])
      );
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         any_q <= 1'b0;
      end else begin
         any_q <= |btn_press;
      end
   end

   assign any_press = any_q;

endmodule

// File: tb/tb_button_reader.sv
// Self-checking bench: directed event tables, corner sequences and random
// stimulus against a run-length reference model.
module tb_button_reader;

   localparam int N = 4;
   localparam int D = 4;
   localparam int L = 10;

   logic         clk = 1'b0;
   logic         rst_in;
   logic [N-1:0] btn_raw;
   logic [N-1:0] btn_level, btn_press, btn_release, btn_long;
   logic         any_press;

   int checks = 0;
   int errors = 0;

   button_reader #(
      .NUM_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1)
   ) dut (
      .clk_in(clk), .rst_in(rst_in), .btn_raw(btn_raw),
      .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
      .btn_long(btn_long), .any_press(any_press)
   );

   always #5 clk = ~clk;

   // Reference model: a level change is accepted after D+1 consecutive
   // synchronised samples that disagree with the current level.
   logic [N-1:0] m_p1, m_p2, m_level, m_press, m_rel, m_long;
   logic         m_any;
   int           m_run [N];
   int           m_hold [N];

   task automatic model_reset();
      m_p1 = '0; m_p2 = '0; m_level = '0; m_press = '0; m_rel = '0; m_long = '0;
      m_any = 1'b0;
      for (int i = 0; i < N; i++) begin m_run[i] = 0; m_hold[i] = 0; end
   endtask

   task automatic model_step(input logic [N-1:0] raw);
      logic [N-1:0] s;
      s = m_p2;
      m_p2 = m_p1;
      m_p1 = ~raw;
      m_any = |m_press;
      m_press = '0; m_rel = '0; m_long = '0;
      for (int i = 0; i < N; i++) begin
         if (m_level[i] && m_run[i] == 0 && m_hold[i] < L - 1) begin
            m_hold[i]++;
            if (m_hold[i] == L - 1) m_long[i] = 1'b1;
         end
         m_run[i] = (s[i] != m_level[i]) ? m_run[i] + 1 : 0;
         if (m_run[i] == D + 1) begin
            m_run[i] = 0;
            m_level[i] = ~m_level[i];
            if (m_level[i]) begin m_press[i] = 1'b1; m_hold[i] = 0; end
            else m_rel[i] = 1'b1;
         end
      end
   endtask

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%b expected=%b t=%0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock edge, update the model, compare all outputs.
   task automatic tick();
      @(posedge clk);
      if (rst_in) model_reset();
      else model_step(btn_raw);
      #1;
      chk("level", btn_level, m_level);
      chk("press", btn_press, m_press);
      chk("release", btn_release, m_rel);
      chk("long", btn_long, m_long);
      chk("any", {3'b0, any_press}, {3'b0, m_any});
   endtask

   typedef struct {
      logic [N-1:0] mask;
      int           hold;
      int           pc;
      int           lc;
      int           rc;
   } vec_t;

   vec_t vecs [6];
   int   seq_cnt;
   int   rem [N];

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout t=%0t", $time);
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{4'b0001, 10, 6, -1, 16};
      vecs[1] = '{4'b0100, 20, 6, 15, 26};
      vecs[2] = '{4'b1111, 8, 6, -1, 14};
      vecs[3] = '{4'b0010, 3, -1, -1, -1};
      vecs[4] = '{4'b1000, 4, -1, -1, -1};
      vecs[5] = '{4'b1000, 5, 6, -1, 11};

      rst_in = 1'b1;
      btn_raw = '1;
      model_reset();
      repeat (3) tick();
      chk("reset_outputs", btn_level | btn_press | btn_release | btn_long, '0);
      rst_in = 1'b0;
      repeat (5) tick();

      // Directed event timing; cycle c is observed just after edge c.
      for (int v = 0; v < 6; v++) begin
         for (int c = 0; c <= vecs[v].hold + 10; c++) begin
            btn_raw = (c < vecs[v].hold) ? ~vecs[v].mask : '1;
            tick();
            chk("tbl_press", btn_press, (c == vecs[v].pc) ? vecs[v].mask : '0);
            chk("tbl_long", btn_long, (c == vecs[v].lc) ? vecs[v].mask : '0);
            chk("tbl_release", btn_release, (c == vecs[v].rc) ? vecs[v].mask : '0);
            chk("tbl_level", btn_level,
                (vecs[v].pc >= 0 && c >= vecs[v].pc && c < vecs[v].rc) ? vecs[v].mask : '0);
            chk("tbl_any", {3'b0, any_press},
                {3'b0, (vecs[v].pc >= 0 && c == vecs[v].pc + 1)});
         end
         repeat (8) tick();
      end

      // Bounce on channel 1: 3-cycle low/high widths never qualify.
      for (int c = 0; c < 40; c++) begin
         btn_raw = '1;
         if (c < 30) btn_raw[1] = ((c / 3) % 2 == 0) ? 1'b0 : 1'b1;
         tick();
         chk("bounce_ch1", {btn_level[1], btn_press[1], btn_release[1], btn_long[1]}, '0);
      end

      // Release glitch while held: no release, level holds, long once.
      seq_cnt = 0;
      for (int c = 0; c <= 52; c++) begin
         btn_raw = '1;
         btn_raw[0] = (c <= 40 && c != 20 && c != 21) ? 1'b0 : 1'b1;
         tick();
         if (btn_long[0]) seq_cnt++;
         chk("glitch_level", {3'b0, btn_level[0]}, {3'b0, (c >= 6 && c < 47)});
         chk("glitch_release", {3'b0, btn_release[0]}, {3'b0, (c == 47)});
      end
      chk("glitch_long_count", N'(seq_cnt), N'(1));
      repeat (5) tick();

      // Reset mid-press, button still held through deassertion.
      for (int c = 0; c <= 8; c++) begin
         btn_raw = 4'b0111;
         tick();
      end
      #2 rst_in = 1'b1;
      model_reset();
      #1;
      chk("rst_async_zero", btn_level | btn_press | btn_release | btn_long, '0);
      chk("rst_async_any", {3'b0, any_press}, '0);
      repeat (2) tick();
      rst_in = 1'b0;
      for (int c = 0; c <= 10; c++) begin
         tick();
         chk("rst_repress", {3'b0, btn_press[3]}, {3'b0, (c == 6)});
         chk("rst_no_release", {3'b0, btn_release[3]}, '0);
      end
      btn_raw = '1;
      repeat (10) tick();

      // Random hold/bounce lengths with occasional resets.
      for (int i = 0; i < N; i++) rem[i] = $urandom_range(1, 12);
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < N; i++) begin
            rem[i]--;
            if (rem[i] <= 0) begin
               btn_raw[i] = ~btn_raw[i];
               rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 25)
                                                    : $urandom_range(1, 7);
            end
         end
         if ($urandom_range(0, 399) == 0) begin
            rst_in = 1'b1;
            model_reset();
            tick();
            rst_in = 1'b0;
         end else begin
            tick();
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
